instruction_fetch_stage: RTL and testbench
==========================================

INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

Interface
REQ-001 SHALL have ports, one per line: name  direction  width  meaning.
REQ-002 CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 STALL  input  1  hazard unit holds the IF/ID outputs.
REQ-005 BRANCH_TAKEN  input  1  redirect request from EX.
REQ-006 BRANCH_TARGET  input  32  redirect byte address.
REQ-007 IMEM_READDATA  input  32  instruction word from instruction memory.
REQ-008 IMEM_BUSYWAIT  input  1  instruction memory not ready; data invalid while 1.
REQ-009 IMEM_READ  output  1  fetch request.
REQ-010 IMEM_ADDRESS  output  32  fetch byte address.
REQ-011 IFID_PC  output  32  PC of the registered instruction.
REQ-012 IFID_PC4  output  32  IFID_PC+4.
REQ-013 IFID_INSTRUCTION  output  32  registered instruction word, consumed by the control unit decode.
REQ-014 IFID_VALID  output  1  IF/ID holds a real instruction.
REQ-015 MISALIGN_FAULT  output  1  one-cycle pulse on a misaligned redirect.

Function
REQ-016 SHALL implement three states: FETCH (request outstanding), HELD (word captured, downstream stalled), DRAIN (discarding a stale outstanding fetch).
REQ-017 SHALL hold PC (32 b); in FETCH, IMEM_READ=1 and IMEM_ADDRESS=PC.
REQ-018 Fetch completion SHALL be a rising edge with IMEM_READ=1 and IMEM_BUSYWAIT=0; IMEM_READDATA is sampled at that edge.
REQ-019 In FETCH, on completion with STALL=0, the stage SHALL load IFID_PC=PC, IFID_PC4=PC+4, IFID_INSTRUCTION=IMEM_READDATA, IFID_VALID=1, set PC=PC+4, and stay in FETCH (1 instruction/cycle at zero wait).
REQ-020 In FETCH, on completion with STALL=1, the stage SHALL capture the word in a holding buffer, leave the IF/ID outputs unchanged, and go to HELD.
REQ-021 In FETCH, without completion, STALL=0 SHALL load a bubble (IFID_INSTRUCTION=0x00000013, IFID_VALID=0); STALL=1 SHALL hold the IF/ID outputs.
REQ-022 In HELD, IMEM_READ SHALL be 0; when STALL=0, the stage SHALL move the buffer to IF/ID (VALID=1), set PC=PC+4, and go to FETCH.
REQ-023 BRANCH_TAKEN=1 SHALL take priority over STALL and over completion: the stage SHALL load the IF/ID bubble (VALID=0, NOP), discard the holding buffer, and set PC={BRANCH_TARGET[31:2],2'b00}.
REQ-024 On redirect, if the state is FETCH and IMEM_BUSYWAIT=1, the stage SHALL go to DRAIN; otherwise it SHALL go to FETCH.
REQ-025 In DRAIN, IMEM_READ SHALL stay 1 and IMEM_ADDRESS SHALL hold the old address until completion; the returned word SHALL be discarded, then the stage SHALL go to FETCH at the new PC.
REQ-026 A redirect while in DRAIN SHALL update PC only and remain in DRAIN.
REQ-027 If BRANCH_TARGET[1:0]!=0 on a redirect, MISALIGN_FAULT SHALL be 1 for the following cycle only.
REQ-028 PC arithmetic SHALL be modulo 2^32; 0xFFFFFFFC+4 SHALL wrap to 0x00000000.

Reset
REQ-029 While RESET=1 at an edge: PC=0x00000000, state=FETCH, IFID_PC=0, IFID_PC4=4, IFID_INSTRUCTION=0x00000013, IFID_VALID=0, MISALIGN_FAULT=0, holding buffer cleared.
REQ-030 IMEM_READ SHALL be 0 while RESET=1, and 1 in the first cycle after release.
REQ-031 A reset asserted in HELD or DRAIN SHALL abandon the stage's state with no pending output.

Verification
REQ-032 Zero-wait memory, reset release -> IFID_PC 0,4,8 on three consecutive edges, IFID_VALID=1 each.
REQ-033 BUSYWAIT=1 for 2 cycles at PC=8 -> 2 bubbles (VALID=0, 0x00000013), then IFID_PC=8 with the memory word.
REQ-034 STALL=1 for 3 cycles during completion at PC=0x10 -> HELD, IMEM_READ=0, IF/ID unchanged; STALL release -> IFID_PC=0x10, next fetch at 0x14.
REQ-035 BRANCH_TAKEN with target 0x40 while BUSYWAIT=1 at PC=0x20 -> DRAIN; stale word dropped; next valid IFID_PC=0x40.
REQ-036 Redirect to 0x43 -> PC=0x40, MISALIGN_FAULT high exactly one cycle.
REQ-037 PC=0xFFFFFFFC completion, then RESET mid-HELD -> wrap gives PC=0; reset returns all REQ-029 values.

Source files
------------

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC, fetch request handshake and IF/ID pipeline register.
// Handles downstream stalls with a one-word holding buffer and drops stale fetches after a redirect.
module instruction_fetch_stage (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] imem_readdata_i,
  input  logic        imem_busywait_i,
  output logic        imem_read_o,
  output logic [31:0] imem_address_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_pc4_o,
  output logic [31:0] ifid_instruction_o,
  output logic        ifid_valid_o,
  output logic        misalign_fault_o
);

  // state  | meaning
  // FETCH  | request outstanding at pc_q
  // HELD   | word captured in hold_q, downstream stalled, no request
  // DRAIN  | stale request at drain_addr_q outstanding, its word is discarded
  typedef enum logic [1:0] {S_FETCH, S_HELD, S_DRAIN} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] drain_addr_q;
  logic [31:0] hold_q;
  logic [31:0] ifid_pc_q;
  logic [31:0] ifid_pc4_q;
  logic [31:0] ifid_instr_q;
  logic        ifid_valid_q;
  logic        fault_q;
  logic        fetch_done;
  logic [31:0] pc_inc;

  assign imem_read_o    = ~reset_i & (state_q != S_HELD);
  assign imem_address_o = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
  assign fetch_done     = imem_read_o & ~imem_busywait_i;
  assign pc_inc         = pc_q + 32'd4;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_FETCH;
      pc_q         <= 32'h0;
      drain_addr_q <= 32'h0;
      hold_q       <= 32'h0;
      ifid_pc_q    <= 32'h0;
      ifid_pc4_q   <= 32'd4;
      ifid_instr_q <= NOP;
      ifid_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      fault_q <= 1'b0;
      if (branch_taken_i) begin
        pc_q    <= {branch_target_i[31:2], 2'b00};
        fault_q <= |branch_target_i[1:0];
        hold_q  <= 32'h0;
        if (state_q == S_DRAIN) begin
          // IF/ID already holds a bubble; only leave DRAIN once the stale word has returned
          if (fetch_done) state_q <= S_FETCH;
        end else begin
          ifid_instr_q <= NOP;
          ifid_valid_q <= 1'b0;
          if (state_q == S_FETCH && imem_busywait_i) begin
            state_q      <= S_DRAIN;
            drain_addr_q <= pc_q;
          end else begin
            state_q <= S_FETCH;
          end
        end
      end else begin
        case (state_q)
          S_FETCH: begin
            if (fetch_done) begin
              if (!stall_i) begin
                ifid_pc_q    <= pc_q;
                ifid_pc4_q   <= pc_inc;
                ifid_instr_q <= imem_readdata_i;
                ifid_valid_q <= 1'b1;
                pc_q         <= pc_inc;
              end else begin
                hold_q  <= imem_readdata_i;
                state_q <= S_HELD;
              end
            end else if (!stall_i) begin
              ifid_instr_q <= NOP;
              ifid_valid_q <= 1'b0;
            end
          end
          S_HELD: begin
            if (!stall_i) begin
              ifid_pc_q    <= pc_q;
              ifid_pc4_q   <= pc_inc;
              ifid_instr_q <= hold_q;
              ifid_valid_q <= 1'b1;
              pc_q         <= pc_inc;
              state_q      <= S_FETCH;
            end
          end
          S_DRAIN: begin
            if (fetch_done) state_q <= S_FETCH;
          end
          default: state_q <= S_FETCH;
        endcase
      end
    end
  end

  assign ifid_pc_o          = ifid_pc_q;
  assign ifid_pc4_o         = ifid_pc4_q;
  assign ifid_instruction_o = ifid_instr_q;
  assign ifid_valid_o       = ifid_valid_q;
  assign misalign_fault_o   = fault_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with a combinational instruction memory model.
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, busywait;
  logic [31:0] branch_target, readdata;
  logic        imem_read, ifid_valid, fault;
  logic [31:0] imem_address, ifid_pc, ifid_pc4, ifid_instr;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign readdata = word(imem_address);

  instruction_fetch_stage dut (
    .clk_i(clk), .reset_i(reset), .stall_i(stall), .branch_taken_i(branch_taken),
    .branch_target_i(branch_target), .imem_readdata_i(readdata), .imem_busywait_i(busywait),
    .imem_read_o(imem_read), .imem_address_o(imem_address), .ifid_pc_o(ifid_pc),
    .ifid_pc4_o(ifid_pc4), .ifid_instruction_o(ifid_instr), .ifid_valid_o(ifid_valid),
    .misalign_fault_o(fault)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; busywait = 1'b0; branch_target = 32'h0;
    cyc(); cyc();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; busywait = 1'b0; branch_target = 32'h0;
    cyc(); cyc();
    total++; if (imem_read !== 1'b0) begin bad++; $display("FAIL reset_read got=%b exp=0", imem_read); end
    total++; if (ifid_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", ifid_pc); end
    total++; if (ifid_pc4 !== 32'h4) begin bad++; $display("FAIL reset_pc4 got=%h exp=4", ifid_pc4); end
    total++; if (ifid_instr !== 32'h13) begin bad++; $display("FAIL reset_instr got=%h exp=13", ifid_instr); end
    total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ifid_valid); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", fault); end
    total++; if (imem_address !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", imem_address); end
    reset = 1'b0;
    #1;
    total++; if (imem_read !== 1'b1) begin bad++; $display("FAIL release_read got=%b exp=1", imem_read); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp_pc;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'(i * 4);
      cyc();
      total++; if (ifid_pc !== exp_pc || ifid_valid !== 1'b1 || ifid_instr !== word(exp_pc) || ifid_pc4 !== exp_pc + 32'd4) begin
        bad++; $display("FAIL zero_wait pc=%h v=%b ins=%h pc4=%h exp_pc=%h", ifid_pc, ifid_valid, ifid_instr, ifid_pc4, exp_pc);
      end
    end
  endtask

  task automatic test_busywait();
    do_reset();
    cyc(); cyc();
    busywait = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      total++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h13) begin
        bad++; $display("FAIL bubble v=%b ins=%h exp v=0 ins=13", ifid_valid, ifid_instr);
      end
      total++; if (imem_address !== 32'h8 || imem_read !== 1'b1) begin
        bad++; $display("FAIL bw_addr addr=%h rd=%b exp 8/1", imem_address, imem_read);
      end
    end
    busywait = 1'b0;
    cyc();
    total++; if (ifid_pc !== 32'h8 || ifid_valid !== 1'b1 || ifid_instr !== 32'hC0DE_0008 || ifid_pc4 !== 32'hC) begin
      bad++; $display("FAIL bw_done pc=%h v=%b ins=%h pc4=%h exp 8/1/c0de0008/c", ifid_pc, ifid_valid, ifid_instr, ifid_pc4);
    end
  endtask

  task automatic test_stall();
    cyc();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++; if (imem_read !== 1'b0) begin bad++; $display("FAIL held_read got=%b exp=0", imem_read); end
      total++; if (ifid_pc !== 32'hC || ifid_valid !== 1'b1 || ifid_instr !== 32'hC0DE_000C) begin
        bad++; $display("FAIL held_ifid pc=%h v=%b ins=%h exp c/1/c0de000c", ifid_pc, ifid_valid, ifid_instr);
      end
    end
    stall = 1'b0;
    cyc();
    total++; if (ifid_pc !== 32'h10 || ifid_valid !== 1'b1 || ifid_instr !== 32'hC0DE_0010) begin
      bad++; $display("FAIL unstall pc=%h v=%b ins=%h exp 10/1/c0de0010", ifid_pc, ifid_valid, ifid_instr);
    end
    total++; if (imem_address !== 32'h14 || imem_read !== 1'b1) begin
      bad++; $display("FAIL unstall_addr addr=%h rd=%b exp 14/1", imem_address, imem_read);
    end
    cyc();
    total++; if (ifid_pc !== 32'h14 || ifid_instr !== 32'hC0DE_0014) begin
      bad++; $display("FAIL after_unstall pc=%h ins=%h exp 14/c0de0014", ifid_pc, ifid_instr);
    end
  endtask

  task automatic test_drain();
    cyc(); cyc();
    total++; if (imem_address !== 32'h20) begin bad++; $display("FAIL pre_drain addr=%h exp=20", imem_address); end
    busywait = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
    cyc();
    branch_taken = 1'b0;
    total++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h13 || fault !== 1'b0) begin
      bad++; $display("FAIL redirect_bubble v=%b ins=%h f=%b exp 0/13/0", ifid_valid, ifid_instr, fault);
    end
    total++; if (imem_address !== 32'h20 || imem_read !== 1'b1) begin
      bad++; $display("FAIL drain_addr addr=%h rd=%b exp 20/1", imem_address, imem_read);
    end
    cyc();
    total++; if (imem_address !== 32'h20) begin bad++; $display("FAIL drain_hold addr=%h exp=20", imem_address); end
    busywait = 1'b0;
    cyc();
    total++; if (ifid_valid !== 1'b0 || imem_address !== 32'h40) begin
      bad++; $display("FAIL drain_drop v=%b addr=%h exp 0/40", ifid_valid, imem_address);
    end
    cyc();
    total++; if (ifid_pc !== 32'h40 || ifid_valid !== 1'b1 || ifid_instr !== 32'hC0DE_0040) begin
      bad++; $display("FAIL post_drain pc=%h v=%b ins=%h exp 40/1/c0de0040", ifid_pc, ifid_valid, ifid_instr);
    end
  endtask

  task automatic test_drain_redirect();
    busywait = 1'b1; branch_taken = 1'b1; branch_target = 32'h80;
    cyc();
    total++; if (imem_address !== 32'h44) begin bad++; $display("FAIL drain2_addr addr=%h exp=44", imem_address); end
    branch_target = 32'h100;
    cyc();
    branch_taken = 1'b0;
    total++; if (imem_address !== 32'h44 || imem_read !== 1'b1) begin
      bad++; $display("FAIL drain_redirect addr=%h rd=%b exp 44/1", imem_address, imem_read);
    end
    busywait = 1'b0;
    cyc();
    total++; if (imem_address !== 32'h100 || ifid_valid !== 1'b0) begin
      bad++; $display("FAIL drain2_exit addr=%h v=%b exp 100/0", imem_address, ifid_valid);
    end
    cyc();
    total++; if (ifid_pc !== 32'h100 || ifid_valid !== 1'b1) begin
      bad++; $display("FAIL drain2_fetch pc=%h v=%b exp 100/1", ifid_pc, ifid_valid);
    end
  endtask

  task automatic test_misalign();
    branch_taken = 1'b1; branch_target = 32'h43;
    cyc();
    branch_taken = 1'b0;
    total++; if (fault !== 1'b1) begin bad++; $display("FAIL fault_set got=%b exp=1", fault); end
    total++; if (imem_address !== 32'h40 || ifid_valid !== 1'b0) begin
      bad++; $display("FAIL misalign_pc addr=%h v=%b exp 40/0", imem_address, ifid_valid);
    end
    cyc();
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL fault_clear got=%b exp=0", fault); end
    total++; if (ifid_pc !== 32'h40 || ifid_valid !== 1'b1) begin
      bad++; $display("FAIL misalign_fetch pc=%h v=%b exp 40/1", ifid_pc, ifid_valid);
    end
  endtask

  task automatic test_wrap_reset();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    cyc();
    branch_taken = 1'b0;
    total++; if (imem_address !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr addr=%h exp=fffffffc", imem_address); end
    cyc();
    total++; if (ifid_pc !== 32'hFFFF_FFFC || ifid_pc4 !== 32'h0 || imem_address !== 32'h0) begin
      bad++; $display("FAIL wrap pc=%h pc4=%h addr=%h exp fffffffc/0/0", ifid_pc, ifid_pc4, imem_address);
    end
    stall = 1'b1;
    cyc();
    total++; if (imem_read !== 1'b0) begin bad++; $display("FAIL wrap_held rd=%b exp=0", imem_read); end
    reset = 1'b1; stall = 1'b0;
    cyc();
    total++; if (imem_read !== 1'b0 || ifid_pc !== 32'h0 || ifid_pc4 !== 32'h4 || ifid_instr !== 32'h13 || ifid_valid !== 1'b0 || fault !== 1'b0) begin
      bad++; $display("FAIL held_reset rd=%b pc=%h pc4=%h ins=%h v=%b f=%b", imem_read, ifid_pc, ifid_pc4, ifid_instr, ifid_valid, fault);
    end
    reset = 1'b0;
    #1;
    total++; if (imem_read !== 1'b1 || imem_address !== 32'h0) begin
      bad++; $display("FAIL reset_exit rd=%b addr=%h exp 1/0", imem_read, imem_address);
    end
    cyc();
    total++; if (ifid_pc !== 32'h0 || ifid_valid !== 1'b1 || ifid_instr !== 32'hC0DE_0000) begin
      bad++; $display("FAIL first_after_reset pc=%h v=%b ins=%h exp 0/1/c0de0000", ifid_pc, ifid_valid, ifid_instr);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_busywait();
    test_stall();
    test_drain();
    test_drain_redirect();
    test_misalign();
    test_wrap_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
